// File: rtl/proc_pkg.sv
// Shared processor constants for the register file: default data width, register
// count, address width and the zero-register index, plus the address-width helper.
package proc_pkg;

    localparam int DATA_W       = 16;
    localparam int REG_COUNT    = 8;
    localparam int REG_ADDR_W   = 3;
    localparam int ZERO_REG_IDX = 0;

    // Address bits needed to index `depth` registers, never fewer than one.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/reg_file_2r1w_if.sv
// Write port plus two read ports of the 2-read/1-write register file.
// The master drives addresses and enables; the slave returns read data and valids.
interface reg_file_2r1w_if
    import proc_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = REG_COUNT
);

    localparam int ADDR_W = addr_width(DEPTH);

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [WIDTH-1:0]  wdata;
    logic              re0;
    logic [ADDR_W-1:0] raddr0;
    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [WIDTH-1:0]  Q0;
    logic [WIDTH-1:0]  Q1;
    logic              valid0;
    logic              valid1;

    modport master (
        output we, waddr, wdata, re0, raddr0, re1, raddr1,
        input  Q0, Q1, valid0, valid1
    );

    modport slave (
        input  we, waddr, wdata, re0, raddr0, re1, raddr1,
        output Q0, Q1, valid0, valid1
    );

endinterface

// File: rtl/reg_file_read_port.sv
// One registered read port: DEPTH:1 select, range/zero-register masking, optional
// write-through forwarding (REG_FILE_BYPASS_EN) and the Q/valid output flops.
module reg_file_read_port
    import proc_pkg::*;
#(
    parameter int WIDTH    = DATA_W,
    parameter int DEPTH    = REG_COUNT,
    parameter int ZERO_REG = 0,
    localparam int ADDR_W  = addr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  mem [DEPTH],
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  q,
    output logic              valid
);

    logic [WIDTH-1:0] sel;
    logic [WIDTH-1:0] q_d,     q_q;
    logic             valid_d, valid_q;

    // An address matching no register leaves sel at zero, so out-of-range reads return 0.
    always_comb begin
        sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr == ADDR_W'(i)) sel = mem[i];
        end
        if (ZERO_REG != 0 && raddr == ADDR_W'(ZERO_REG_IDX)) sel = '0;
`ifdef REG_FILE_BYPASS_EN
        // wr_en already excludes the zero register and out-of-range addresses.
        if (wr_en && waddr == raddr) sel = wdata;
`endif
    end

`ifndef REG_FILE_BYPASS_EN
    logic unused_bypass;
    assign unused_bypass = ^{wr_en, waddr, wdata};
`endif

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        q_d     = q_q;
        valid_d = 1'b0;
        if (re) begin
            q_d     = sel;
            valid_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking (<=) so all flops sample pre-edge values together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            valid_q <= valid_d;
        end
    end

    assign q     = q_q;
    assign valid = valid_q;

endmodule

// File: rtl/reg_file_2r1w.sv
// DEPTH x WIDTH register file, one synchronous write port, two registered read ports.
// Define REG_FILE_BYPASS_EN to forward same-edge write data to a matching read.
module reg_file_2r1w
    import proc_pkg::*;
#(
    parameter int WIDTH    = DATA_W,
    parameter int DEPTH    = REG_COUNT,
    parameter int ZERO_REG = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    reg_file_2r1w_if.slave  bus
);

    localparam int ADDR_W = addr_width(DEPTH);

    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_en;

    // Writes to nonexistent registers or to a hard-wired zero register are dropped.
    always_comb begin
        wr_en = bus.we && (32'(bus.waddr) < DEPTH);
        if (ZERO_REG != 0 && bus.waddr == ADDR_W'(ZERO_REG_IDX)) wr_en = 1'b0;
    end

    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en && bus.waddr == ADDR_W'(i)) mem_d[i] = bus.wdata;
        end
    end

    // NOTE: the storage array is reset because a read must never return X after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mem_q <= '{default: '0};
        else        mem_q <= mem_d;
    end

    reg_file_read_port #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_rd0 (
        .clk   (clk),
        .rst_n (rst_n),
        .mem   (mem_q),
        .re    (bus.re0),
        .raddr (bus.raddr0),
        .wr_en (wr_en),
        .waddr (bus.waddr),
        .wdata (bus.wdata),
        .q     (bus.Q0),
        .valid (bus.valid0)
    );

    reg_file_read_port #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_rd1 (
        .clk   (clk),
        .rst_n (rst_n),
        .mem   (mem_q),
        .re    (bus.re1),
        .raddr (bus.raddr1),
        .wr_en (wr_en),
        .waddr (bus.waddr),
        .wdata (bus.wdata),
        .q     (bus.Q1),
        .valid (bus.valid1)
    );

endmodule
